decode_alu6: RTL and testbench



---
 rtl/decode_alu6_pkg.sv | 26 ++
 rtl/decode_alu6_comb.sv | 26 ++
 rtl/decode_alu6.sv | 43 ++++
 tb/tb_decode_alu6.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_alu6_pkg.sv
// decode_alu6 shared constants: 6-bit opcodes and {Ctrl0,Ctrl1} class codes.
// Opcode bit 5 is Ctrl0 and bit 0 is Ctrl5, so each value reads like the op string.
package decode_alu6_pkg;

  localparam logic [5:0] OP_ADD = 6'b010010;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_OR  = 6'b001010;
  localparam logic [5:0] OP_NOT = 6'b001100;
  localparam logic [5:0] OP_XOR = 6'b001110;
  localparam logic [5:0] OP_AND = 6'b000110;
  localparam logic [5:0] OP_MOV = 6'b000000;
  localparam logic [5:0] OP_INC = 6'b011011;
  localparam logic [5:0] OP_DEC = 6'b011000;
  localparam logic [5:0] OP_SLA = 6'b100100;
  localparam logic [5:0] OP_SLL = 6'b100000;
  localparam logic [5:0] OP_ROL = 6'b100010;
  localparam logic [5:0] OP_SRA = 6'b101100;
  localparam logic [5:0] OP_SRL = 6'b101000;
  localparam logic [5:0] OP_ROR = 6'b101010;

  localparam logic [1:0] CLS_ARITH = 2'b01;
  localparam logic [1:0] CLS_LOGIC = 2'b00;
  localparam logic [1:0] CLS_SHIFT = 2'b10;
  localparam logic [1:0] CLS_RSVD  = 2'b11;

endpackage

// File: rtl/decode_alu6_comb.sv
// decode_alu6_comb: combinational next value of the ALU carry/shift-in bit.
// Ports: Ctrl0, Ctrl1, Ctrl4, Ctrl5, c_flag in; o_next out.
module decode_alu6_comb
  import decode_alu6_pkg::*;
(
  input  logic Ctrl0,
  input  logic Ctrl1,
  input  logic Ctrl4,
  input  logic Ctrl5,
  input  logic c_flag,
  output logic o_next
);

  logic w_n0;
  logic w_n1;
  logic w_arith_n;
  logic w_shift_n;

  // next = (~C0 & C1 & C5) | (C0 & ~C1 & C4 & cf), as NAND-NAND
  nand u_inv0 (w_n0, Ctrl0, Ctrl0);
  nand u_inv1 (w_n1, Ctrl1, Ctrl1);
  nand u_arith (w_arith_n, w_n0, Ctrl1, Ctrl5);
  nand u_shift (w_shift_n, Ctrl0, w_n1, Ctrl4, c_flag);
  nand u_or (o_next, w_arith_n, w_shift_n);

endmodule

// File: rtl/decode_alu6.sv
// decode_alu6: registered ALU carry-in / shift-in select bit (one-cycle latency).
// Ports: clk, rst (sync, active-high), Ctrl0..Ctrl5, c_flag in; ALU6_out out.
module decode_alu6
  import decode_alu6_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic Ctrl0,
  input  logic Ctrl1,
  input  logic Ctrl2,
  input  logic Ctrl3,
  input  logic Ctrl4,
  input  logic Ctrl5,
  input  logic c_flag,
  output logic ALU6_out
);

  logic w_next;
  logic r_out;

  // Direction and arithmetic-shift bits never affect the carry/shift-in bit.
  logic w_unused;
  assign w_unused = Ctrl2 ^ Ctrl3;

  decode_alu6_comb u_comb (
    .Ctrl0  (Ctrl0),
    .Ctrl1  (Ctrl1),
    .Ctrl4  (Ctrl4),
    .Ctrl5  (Ctrl5),
    .c_flag (c_flag),
    .o_next (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_out <= 1'b0;
    else
      r_out <= w_next;
  end

  assign ALU6_out = r_out;

endmodule

// File: tb/tb_decode_alu6.sv
// tb_decode_alu6: scoreboard bench for decode_alu6.
// Expected bits are queued at drive time and popped one edge later.
module tb_decode_alu6;
  import decode_alu6_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = 6'b0;
  logic cf = 1'b0;
  logic ALU6_out;

  int n_chk = 0;
  int n_fail = 0;
  logic q[$];

  always #5 clk = ~clk;

  decode_alu6 dut (
    .clk      (clk),
    .rst      (rst),
    .Ctrl0    (op[5]),
    .Ctrl1    (op[4]),
    .Ctrl2    (op[3]),
    .Ctrl3    (op[2]),
    .Ctrl4    (op[1]),
    .Ctrl5    (op[0]),
    .c_flag   (cf),
    .ALU6_out (ALU6_out)
  );

  // Drive one cycle of stimulus, queue its expected result,
  // then wait until just after the edge that registers it.
  task automatic put(input logic [5:0] o, input logic c,
                     input logic r, input logic e);
    @(negedge clk);
    op = o;
    cf = c;
    rst = r;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic e;
    put(OP_SUB, 1'b0, 1'b1, 1'b0);
    e = (q.size() > 0) ? q.pop_front() : 1'bx;
    n_chk++;
    if (ALU6_out !== e) begin
      n_fail++;
      $display("FAIL reset got=%b exp=%b", ALU6_out, e);
    end
    put(OP_SUB, 1'b0, 1'b0, 1'b1);
    e = (q.size() > 0) ? q.pop_front() : 1'bx;
    n_chk++;
    if (ALU6_out !== e) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=%b", ALU6_out, e);
    end
  endtask

  task automatic test_arith();
    logic [5:0] ops [4];
    logic exps [4];
    logic e;
    ops = '{OP_ADD, OP_SUB, OP_INC, OP_DEC};
    exps = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        put(ops[i], c[0], 1'b0, exps[i]);
        e = (q.size() > 0) ? q.pop_front() : 1'bx;
        n_chk++;
        if (ALU6_out !== e) begin
          n_fail++;
          $display("FAIL arith op=%b cf=%0d got=%b exp=%b",
                   ops[i], c, ALU6_out, e);
        end
      end
    end
  endtask

  task automatic test_logic();
    logic [5:0] ops [5];
    logic e;
    ops = '{OP_OR, OP_NOT, OP_XOR, OP_AND, OP_MOV};
    put(OP_SUB, 1'b1, 1'b0, 1'b1);
    void'(q.pop_front());
    for (int i = 0; i < 5; i++) begin
      put(ops[i], 1'b1, 1'b0, 1'b0);
      e = (q.size() > 0) ? q.pop_front() : 1'bx;
      n_chk++;
      if (ALU6_out !== e) begin
        n_fail++;
        $display("FAIL logic op=%b got=%b exp=%b", ops[i], ALU6_out, e);
      end
    end
  endtask

  task automatic test_rotate();
    logic [5:0] ops [2];
    logic cfs [3];
    logic e;
    ops = '{OP_ROL, OP_ROR};
    cfs = '{1'b0, 1'b1, 1'b0};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        put(ops[r], cfs[i], 1'b0, cfs[i]);
        e = (q.size() > 0) ? q.pop_front() : 1'bx;
        n_chk++;
        if (ALU6_out !== e) begin
          n_fail++;
          $display("FAIL rotate op=%b cf=%b got=%b exp=%b",
                   ops[r], cfs[i], ALU6_out, e);
        end
      end
    end
  endtask

  task automatic test_shift();
    logic [5:0] ops [4];
    logic e;
    ops = '{OP_SLA, OP_SLL, OP_SRA, OP_SRL};
    for (int i = 0; i < 4; i++) begin
      put(OP_ROL, 1'b1, 1'b0, 1'b1);
      void'(q.pop_front());
      put(ops[i], 1'b1, 1'b0, 1'b0);
      e = (q.size() > 0) ? q.pop_front() : 1'bx;
      n_chk++;
      if (ALU6_out !== e) begin
        n_fail++;
        $display("FAIL shift op=%b got=%b exp=%b", ops[i], ALU6_out, e);
      end
    end
  endtask

  task automatic test_rsvd();
    logic [5:0] ops [4];
    logic e;
    ops = '{6'b110010, 6'b111111, 6'b110011, 6'b111010};
    for (int i = 0; i < 4; i++) begin
      put(OP_INC, 1'b1, 1'b0, 1'b1);
      void'(q.pop_front());
      put(ops[i], 1'b1, 1'b0, 1'b0);
      e = (q.size() > 0) ? q.pop_front() : 1'bx;
      n_chk++;
      if (ALU6_out !== e) begin
        n_fail++;
        $display("FAIL rsvd op=%b got=%b exp=%b", ops[i], ALU6_out, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [7];
    logic rs [7];
    logic exps [7];
    logic e;
    ops = '{OP_ADD, OP_SUB, OP_ROL, OP_MOV, OP_SUB, OP_ROL, OP_INC};
    rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exps = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      put(ops[i], 1'b1, rs[i], exps[i]);
      e = (q.size() > 0) ? q.pop_front() : 1'bx;
      n_chk++;
      if (ALU6_out !== e) begin
        n_fail++;
        $display("FAIL b2b step=%0d op=%b rst=%b got=%b exp=%b",
                 i, ops[i], rs[i], ALU6_out, e);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] o;
    logic c;
    logic x;
    logic e;
    for (int i = 0; i < 64; i++) begin
      o = 6'($urandom_range(0, 63));
      c = 1'($urandom_range(0, 1));
      unique case (o[5:4])
        CLS_ARITH: x = o[0];
        CLS_SHIFT: x = o[1] & c;
        default:   x = 1'b0;
      endcase
      put(o, c, 1'b0, x);
      e = (q.size() > 0) ? q.pop_front() : 1'bx;
      n_chk++;
      if (ALU6_out !== e) begin
        n_fail++;
        $display("FAIL random op=%b cf=%b got=%b exp=%b", o, c, ALU6_out, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_rotate();
    test_shift();
    test_rsvd();
    test_back_to_back();
    test_random();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
